// File: rtl/pcs_rx_pkg.sv
// Shared RX PCS definitions: idle block pattern, decoder state indices,
// and the clock-compensation scheduler state encoding.
package pcs_rx_pkg;

  localparam logic [65:0] PCS_IDLE = 66'h2_1e_00_00_00_00_00_00_00;

  // Bit positions of the decoder FSM states in its one-hot state vector
  localparam int RX_INIT = 0;
  localparam int RX_C    = 1;
  localparam int RX_D    = 2;
  localparam int RX_T    = 3;
  localparam int RX_E    = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_INSERT = 2'd2,
    S_ERROR  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/comp_deficit_counter.sv
// Saturating up/down counter of deleted AM blocks still owed as idle insertions.
// An increment at the ceiling (without a matching decrement) holds the count
// and raises o_overflow for that cycle.
module comp_deficit_counter #(
  parameter int MAX_COUNT = 40,
  parameter int NB_COUNT  = 6
) (
  input  logic                i_clock,
  input  logic                i_clear,
  input  logic                i_valid,
  input  logic                i_inc,
  input  logic                i_dec,
  output logic [NB_COUNT-1:0] o_count,
  output logic [NB_COUNT-1:0] o_count_next,
  output logic                o_overflow
);

  localparam logic [NB_COUNT-1:0] MAX_W = NB_COUNT'(MAX_COUNT);

  logic [NB_COUNT-1:0] count_q;
  logic [NB_COUNT-1:0] count_d;

  // Next count: simultaneous inc/dec cancel, never wrap in either direction
  always_comb begin
    count_d    = count_q;
    o_overflow = 1'b0;
    if (i_valid) begin
      if (i_inc && !i_dec) begin
        if (count_q == MAX_W) o_overflow = 1'b1;
        else                  count_d    = count_q + NB_COUNT'(1);
      end else if (i_dec && !i_inc && (count_q != '0)) begin
        count_d = count_q - NB_COUNT'(1);
      end
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge i_clock) begin
    if (i_clear) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_count      = count_q;
  assign o_count_next = count_d;

endmodule

// File: rtl/am_idle_comp_scheduler.sv
// RX clock-compensation scheduler: re-inserts one PCS idle per deleted AM
// block while the decoder sits in RX_C and the FIFO head is idle, so the
// decoder never sees an illegal sequence. Drives FIFO pop and idle-mux select.
module am_idle_comp_scheduler
  import pcs_rx_pkg::*;
#(
  parameter int N_LANES           = 20,
  parameter int N_FSM_DECO_STATES = 4,
  parameter int RX_C_IDX          = RX_C,
  parameter int MAX_DEFICIT       = 2 * N_LANES,
  parameter int NB_DEFICIT        = $clog2(MAX_DEFICIT + 1),
  parameter int MAX_BURST         = N_LANES,
  parameter int NB_BURST          = $clog2(MAX_BURST + 1)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_valid,
  input  logic                         i_am_deleted,
  input  logic [N_FSM_DECO_STATES-1:0] i_rx_fsm_state,
  input  logic                         i_head_is_idle,
  input  logic                         i_fifo_empty,
  output logic                         o_insert_idle,
  output logic                         o_fifo_read_enb,
  output logic [NB_DEFICIT-1:0]        o_deficit,
  output logic [1:0]                   o_state,
  output logic                         o_overflow_err,
  output logic                         o_underflow_err
);

  localparam logic [NB_BURST-1:0] MAX_BURST_W = NB_BURST'(MAX_BURST);

  sched_state_t          state_q, state_d;
  logic [NB_BURST-1:0]   burst_q, burst_d;
  logic [NB_DEFICIT-1:0] deficit_q, deficit_next;
  logic                  overflow_q, underflow_q;
  logic                  clear, rx_c, overflow, underflow_set;
  logic                  unused_rx_state;

  // Disabling the block behaves exactly like reset
  assign clear = i_reset | ~i_enable;
  assign rx_c  = i_rx_fsm_state[RX_C_IDX];
  // Only the RX_C bit matters here; the rest of the one-hot vector is ignored
  assign unused_rx_state = ^i_rx_fsm_state;

  comp_deficit_counter #(
    .MAX_COUNT (MAX_DEFICIT),
    .NB_COUNT  (NB_DEFICIT)
  ) u_deficit (
    .i_clock      (i_clock),
    .i_clear      (clear),
    .i_valid      (i_valid & i_enable),
    .i_inc        (i_am_deleted),
    .i_dec        (o_insert_idle),
    .o_count      (deficit_q),
    .o_count_next (deficit_next),
    .o_overflow   (overflow)
  );

  // Zero-latency mux select and FIFO pop from registered state and live inputs
  always_comb begin
    o_insert_idle = 1'b0;
    if (i_enable && i_valid && (deficit_q != '0) && rx_c) begin
      o_insert_idle = ((state_q == S_ARMED) && i_head_is_idle) ||
                      ((state_q == S_INSERT) && (burst_q < MAX_BURST_W));
    end
    o_fifo_read_enb = i_enable & i_valid & ~o_insert_idle & ~i_fifo_empty &
                      (state_q != S_ERROR);
    underflow_set   = i_enable & i_valid & ~o_insert_idle & i_fifo_empty;
  end

  // Next-state and burst-length logic, advancing only on valid cycles
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    if (i_valid) begin
      if (overflow) begin
        state_d = S_ERROR;
        burst_d = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_am_deleted) state_d = S_ARMED;
          end
          S_ARMED: begin
            if (o_insert_idle) begin
              state_d = S_INSERT;
              burst_d = NB_BURST'(1);
            end else if (deficit_next == '0) begin
              state_d = S_IDLE;
            end
          end
          S_INSERT: begin
            // Leaving a burst keeps any remaining deficit for the next idle head
            if (!rx_c || (burst_q == MAX_BURST_W) || (deficit_next == '0)) begin
              burst_d = '0;
              state_d = (deficit_next == '0) ? S_IDLE : S_ARMED;
            end else if (o_insert_idle) begin
              burst_d = burst_q + NB_BURST'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State, burst and sticky error registers
  always_ff @(posedge i_clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      burst_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      if (overflow)      overflow_q  <= 1'b1;
      if (underflow_set) underflow_q <= 1'b1;
    end
  end

  assign o_deficit       = deficit_q;
  assign o_state         = state_q;
  assign o_overflow_err  = overflow_q;
  assign o_underflow_err = underflow_q;

endmodule

// File: tb/tb_am_idle_comp_scheduler.sv
// Directed bench for the idle compensation scheduler (default parameters:
// MAX_DEFICIT=40, MAX_BURST=20).
module tb_am_idle_comp_scheduler;

  localparam logic [3:0] RXC  = 4'b0010;
  localparam logic [3:0] RXI  = 4'b0001;

  logic       clk = 1'b0;
  logic       rst, en, vld, am, head_idle, empty;
  logic [3:0] rx_state;
  logic       insert, rd;
  logic [5:0] deficit;
  logic [1:0] state;
  logic       ovf, unf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  am_idle_comp_scheduler dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_valid         (vld),
    .i_am_deleted    (am),
    .i_rx_fsm_state  (rx_state),
    .i_head_is_idle  (head_idle),
    .i_fifo_empty    (empty),
    .o_insert_idle   (insert),
    .o_fifo_read_enb (rd),
    .o_deficit       (deficit),
    .o_state         (state),
    .o_overflow_err  (ovf),
    .o_underflow_err (unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; vld = 1'b1; am = 1'b0;
    rx_state = RXI; head_idle = 1'b0; empty = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_deficit", 32'(deficit), 0);
    check("rst_state", 32'(state), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_unf", 32'(unf), 0);
    check("rst_insert", 32'(insert), 0);

    // Single AM deletion
    am = 1'b1; tick(); am = 1'b0;
    check("single_deficit", 32'(deficit), 1);
    check("single_armed", 32'(state), 1);
    head_idle = 1'b1; settle();
    check("single_no_rxc", 32'(insert), 0);
    rx_state = RXC; settle();
    check("single_insert", 32'(insert), 1);
    check("single_no_read", 32'(rd), 0);
    tick();
    check("single_def0", 32'(deficit), 0);
    check("single_inserting", 32'(state), 2);
    check("single_one_shot", 32'(insert), 0);
    check("single_read", 32'(rd), 1);
    tick();
    check("single_idle", 32'(state), 0);

    // 22 deletions: burst of 20, cap, then re-arm for the remaining 2
    rx_state = RXI; head_idle = 1'b0; am = 1'b1;
    repeat (22) tick();
    am = 1'b0;
    check("burst_deficit", 32'(deficit), 22);
    rx_state = RXC; head_idle = 1'b1; settle();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("burst_ins%0d", i), 32'(insert), 1);
      tick();
    end
    check("burst_cap_stop", 32'(insert), 0);
    check("burst_cap_def", 32'(deficit), 2);
    tick();
    check("burst_rearmed", 32'(state), 1);
    head_idle = 1'b0; settle();
    check("burst_wait_head", 32'(insert), 0);
    head_idle = 1'b1; settle();
    check("burst_resume", 32'(insert), 1);
    tick();
    check("burst_cont", 32'(insert), 1);
    tick();
    check("burst_done_def", 32'(deficit), 0);
    check("burst_done_state", 32'(state), 0);

    // rx_c lost after 5 of 10 insertions
    rx_state = RXI; am = 1'b1;
    repeat (10) tick();
    am = 1'b0;
    rx_state = RXC; head_idle = 1'b1;
    repeat (5) tick();
    rx_state = RXI; settle();
    check("rxc_drop_stop", 32'(insert), 0);
    tick();
    check("rxc_drop_def", 32'(deficit), 5);
    check("rxc_drop_state", 32'(state), 1);
    rx_state = RXC; head_idle = 1'b0; settle();
    check("rxc_need_head", 32'(insert), 0);
    head_idle = 1'b1;
    tick(); tick();
    check("rxc_resumed_def", 32'(deficit), 3);

    // Valid low: everything holds, outputs quiet
    vld = 1'b0; am = 1'b1; settle();
    check("nvld_insert", 32'(insert), 0);
    check("nvld_read", 32'(rd), 0);
    tick();
    check("nvld_hold", 32'(deficit), 3);
    vld = 1'b1; settle();

    // Deletion and insertion together at deficit 3
    check("simul_insert", 32'(insert), 1);
    tick();
    am = 1'b0;
    check("simul_def", 32'(deficit), 3);
    repeat (3) tick();
    check("drain_def", 32'(deficit), 0);
    check("drain_state", 32'(state), 0);
    check("no_unf_yet", 32'(unf), 0);

    // Overflow: 41 deletions with rx_c low
    rx_state = RXI; am = 1'b1;
    repeat (40) tick();
    check("ovf_at_max", 32'(deficit), 40);
    check("ovf_not_yet", 32'(ovf), 0);
    tick();
    am = 1'b0;
    check("ovf_sat", 32'(deficit), 40);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_state", 32'(state), 3);
    rx_state = RXC; head_idle = 1'b1; settle();
    check("ovf_no_read", 32'(rd), 0);
    check("ovf_no_insert", 32'(insert), 0);
    en = 1'b0; settle();
    check("dis_insert", 32'(insert), 0);
    tick();
    en = 1'b1; settle();
    check("dis_def", 32'(deficit), 0);
    check("dis_state", 32'(state), 0);
    check("dis_ovf", 32'(ovf), 0);

    // Underflow: pop wanted with an empty FIFO
    empty = 1'b1; settle();
    check("unf_no_read", 32'(rd), 0);
    tick();
    empty = 1'b0;
    check("unf_flag", 32'(unf), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("unf_cleared", 32'(unf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/am_idle_comp_scheduler.md
Name: am_idle_comp_scheduler

Overview:
- Controller for the RX clock-compensation FIFO that sits after lane reorder and alignment-marker (AM) removal, ahead of the 64b/66b decoder FSM.
- Keeps a deficit count of deleted AM blocks.
- Schedules one PCS idle insertion per deleted AM, only when the decoder FSM is in RX_C and the FIFO head is an idle block, so the decoder never enters RX_E.
- Drives the FIFO read enable and the idle-mux select.

Parameters:
- N_LANES, 20: lanes aggregated; one AM is deleted per lane per period.
- N_FSM_DECO_STATES, 4: width of the one-hot decoder state input.
- RX_C_IDX, 1: bit index of RX_C within the decoder state vector.
- MAX_DEFICIT, 40: highest legal deficit; a deletion while at this value is an error.
- NB_DEFICIT, 6: deficit width, $clog2(MAX_DEFICIT+1).
- MAX_BURST, 20: maximum back-to-back insertions before re-arming.
- NB_BURST, 5: burst counter width, $clog2(MAX_BURST+1).

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  register-file enable; low clears the block exactly as reset does.
- i_valid  in  1  datapath clock-enable; all state advances only when high.
- i_am_deleted  in  1  the AM block at the FIFO write side is being dropped this cycle.
- i_rx_fsm_state  in  N_FSM_DECO_STATES  one-hot decoder FSM state.
- i_head_is_idle  in  1  the FIFO output word equals PCS_IDLE.
- i_fifo_empty  in  1  FIFO empty flag.
- o_insert_idle  out  1  select PCS_IDLE instead of the FIFO output this cycle.
- o_fifo_read_enb  out  1  pop the FIFO this cycle.
- o_deficit  out  NB_DEFICIT  pending insertions (registered).
- o_state  out  2  FSM state, for debug.
- o_overflow_err  out  1  sticky: deficit overflow.
- o_underflow_err  out  1  sticky: pop attempted while the FIFO is empty.

Behaviour:
- Reset, or i_enable low, sets on the next edge: state=S_IDLE, deficit=0, burst=0, both error flags=0. While i_enable is low, o_insert_idle=0 and o_fifo_read_enb=0.
- States, encoded 0..3:
  - S_IDLE: deficit==0.
  - S_ARMED: deficit>0, waiting for an insertion opportunity.
  - S_INSERT: burst of insertions in progress.
  - S_ERROR: sticky; left only via reset or i_enable low.
- rx_c = i_rx_fsm_state[RX_C_IDX].
- o_insert_idle is combinational from registered state and current inputs, giving zero-cycle latency to the mux. It is asserted when all of the following hold:
  - i_valid
  - deficit>0
  - rx_c
  - (state==S_ARMED and i_head_is_idle) or (state==S_INSERT and burst<MAX_BURST)
- o_fifo_read_enb = i_valid & ~o_insert_idle & ~i_fifo_empty & (state!=S_ERROR).
- o_underflow_err is set when i_valid & ~o_insert_idle & i_fifo_empty & enable.
- Deficit update, on i_valid only:
  - +1 on i_am_deleted.
  - −1 on o_insert_idle.
  - Both in the same cycle: unchanged.
  - deficit==MAX_DEFICIT with i_am_deleted and no insert: hold at MAX_DEFICIT, set o_overflow_err, go to S_ERROR.
  - Never wraps below 0; insertion requires deficit>0.
- Transitions, evaluated on i_valid:
  - S_IDLE → S_ARMED when i_am_deleted.
  - S_ARMED → S_INSERT when o_insert_idle; burst becomes 1.
  - S_INSERT, insert continues: burst += 1.
  - S_INSERT → S_ARMED when ~rx_c, or burst==MAX_BURST, or next deficit==0; burst cleared. Then S_ARMED → S_IDLE if deficit==0.
  - Any state → S_ERROR on overflow.
- In S_ERROR: no insertions; reads continue to be gated off.
- While i_valid is low: all registers hold; outputs o_insert_idle=0 and o_fifo_read_enb=0.
- When rx_c is lost mid-burst, insertion stops that same cycle and the remaining deficit is kept.

Decomposition:
- Shared package pcs_rx_pkg holds:
  - PCS_IDLE, 66'h2_1e_00_00_00_00_00_00_00
  - the decoder state one-hot indices (RX_INIT, RX_C, RX_D, RX_T, RX_E)
  - the scheduler state encodings S_IDLE/S_ARMED/S_INSERT/S_ERROR
- One natural sub-module: comp_deficit_counter, a saturating up/down counter with an overflow flag.
- The FSM and enable logic stay in the top module.

Test Plan:
1. Reset: i_reset=1 for 2 cycles → o_deficit=0, o_state=0, both error flags 0, o_insert_idle=0.
2. Single AM: one i_am_deleted pulse, rx_c=1, i_head_is_idle=1 on the next valid cycle → o_insert_idle=1 for exactly 1 cycle, o_fifo_read_enb=0 that cycle, deficit 1→0, state goes S_ARMED→S_INSERT→S_IDLE.
3. Burst of 20 deletions, then rx_c=1 and head idle → 20 consecutive insertions, deficit 20→0. With MAX_BURST=8, the burst splits at 8 and re-arms on the next idle head.
4. rx_c drops after 5 of 10 insertions → insertion stops the same cycle, deficit=5, state=S_ARMED; it resumes only on rx_c with head idle.
5. Simultaneous i_am_deleted and insertion at deficit=3 → deficit stays 3.
6. 41 deletions with rx_c=0 → deficit saturates at 40, o_overflow_err=1, state=S_ERROR, o_fifo_read_enb=0. i_enable low for 1 cycle → all cleared.
